ibexc_data_sram_bridge: RTL and testbench

Data-side bridge between the CHERIoT Ibex core data port (req/gnt/rvalid, 33-bit data with the capability tag in bit 32) and a single-port tagged data SRAM behind an arbiter. It sits directly downstream of the core top level. Its jobs:
- Decode the address window and return error responses for out-of-window or malformed accesses.
- Enforce tag-clearing on non-capability writes.
- Pipeline SRAM read data back to the core in order, at a fixed latency.

---
 rtl/ibexc_data_sram_bridge.sv | 80 ++++++++
 tb/tb_ibexc_data_sram_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibexc_data_sram_bridge.sv
// ibexc_data_sram_bridge: bridges the core data port to a tagged single-port SRAM.
// Core side : data_req_i/gnt_o/rvalid_o handshake, 33-bit data (bit 32 = tag), data_err_o.
// SRAM side : ram_req_o/gnt_i, word address, byte and tag write enables, fixed-latency rdata.
// Status    : err_cnt_o, saturating count of error responses.
module ibexc_data_sram_bridge #(
    parameter logic [31:0] AddrBase   = 32'h2000_0000,
    parameter int unsigned MemAW      = 14,
    parameter int unsigned RamLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_req_i,
    input  logic             data_is_cap_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [32:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [32:0]      data_rdata_o,
    output logic             data_err_o,
    output logic             ram_req_o,
    input  logic             ram_gnt_i,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic             ram_tag_we_o,
    output logic [MemAW-1:0] ram_addr_o,
    output logic [32:0]      ram_wdata_o,
    input  logic [32:0]      ram_rdata_i,
    output logic [15:0]      err_cnt_o
);
    logic [31:0]           offs;
    logic                  bad;
    logic                  push;
    logic                  unused_offs;
    logic [RamLatency-1:0] vld_d, vld_q, err_d, err_q, we_d, we_q;
    logic [15:0]           err_cnt_d, err_cnt_q;

    // Unsigned wrap makes addresses below AddrBase land far outside the window.
    assign offs        = data_addr_i - AddrBase;
    assign unused_offs = ^offs[1:0];
    assign bad         = (offs[31:MemAW+2] != '0) |
                         (data_is_cap_i & ((data_be_i != 4'hF) | (data_addr_i[1:0] != 2'b00)));

    assign ram_req_o    = data_req_i & ~bad;
    assign data_gnt_o   = data_req_i & (bad | ram_gnt_i);
    assign ram_addr_o   = offs[MemAW+1:2];
    assign ram_be_o     = data_be_i;
    assign ram_we_o     = data_we_i;
    assign ram_tag_we_o = data_we_i;
    // Only capability stores may set the tag; any other store invalidates it.
    assign ram_wdata_o  = {data_is_cap_i & data_wdata_i[32], data_wdata_i[31:0]};
    assign push         = data_req_i & data_gnt_o;

    assign data_rvalid_o = vld_q[RamLatency-1];
    assign data_err_o    = vld_q[RamLatency-1] & err_q[RamLatency-1];
    assign data_rdata_o  = (vld_q[RamLatency-1] & ~err_q[RamLatency-1] & ~we_q[RamLatency-1]) ?
                           ram_rdata_i : 33'h0;
    assign err_cnt_o     = err_cnt_q;

    // Response shift register: new entry at bit 0, output taken from the top bit.
    always_comb begin
        vld_d     = RamLatency'({vld_q, push});
        err_d     = RamLatency'({err_q, bad});
        we_d      = RamLatency'({we_q, data_we_i});
        err_cnt_d = (data_err_o && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            err_cnt_q <= err_cnt_d;
        end
        err_q <= err_d;
        we_q  <= we_d;
    end
endmodule

// File: tb/tb_ibexc_data_sram_bridge.sv
// tb_ibexc_data_sram_bridge: scoreboard bench running latency-1 and latency-2 bridges side by side.
module tb_ibexc_data_sram_bridge;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int MAW = 14;
    localparam longint WIN = 4 * (longint'(1) << MAW);
    localparam int LAT [2] = '{1, 2};

    typedef struct {
        int          cyc;
        logic        err;
        logic [32:0] rdata;
    } exp_t;

    logic        clk, rst;
    logic        data_req, data_is_cap, data_we, ram_gnt;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [32:0] data_wdata;

    logic        data_gnt [2], rvalid [2], data_err [2], ram_req [2], ram_we [2], ram_tag_we [2];
    logic [32:0] rdata [2], ram_wdata [2], ram_rdata [2], rd1 [2], rd2 [2];
    logic [3:0]  ram_be [2];
    logic [MAW-1:0] ram_addr [2];
    logic [15:0] err_cnt [2];

    logic [32:0] env_mem [2][0:(1<<MAW)-1];
    bit   [32:0] ref_mem [int];
    exp_t        q [2][$];
    logic [15:0] cnt_m [2];
    int          cyc, checks, errors;
    bit          armed;

    ibexc_data_sram_bridge #(.AddrBase(BASE), .MemAW(MAW), .RamLatency(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_req_i(data_req), .data_is_cap_i(data_is_cap),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(data_err[0]), .ram_req_o(ram_req[0]), .ram_gnt_i(ram_gnt), .ram_we_o(ram_we[0]),
        .ram_be_o(ram_be[0]), .ram_tag_we_o(ram_tag_we[0]), .ram_addr_o(ram_addr[0]),
        .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]), .err_cnt_o(err_cnt[0]));

    ibexc_data_sram_bridge #(.AddrBase(BASE), .MemAW(MAW), .RamLatency(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(data_req), .data_is_cap_i(data_is_cap),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(data_err[1]), .ram_req_o(ram_req[1]), .ram_gnt_i(ram_gnt), .ram_we_o(ram_we[1]),
        .ram_be_o(ram_be[1]), .ram_tag_we_o(ram_tag_we[1]), .ram_addr_o(ram_addr[1]),
        .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]), .err_cnt_o(err_cnt[1]));

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [32:0] garbage();
        return {1'($urandom), 32'($urandom)};
    endfunction

    // SRAM environment: one tagged memory per DUT, read data delivered after the DUT's latency.
    assign ram_rdata[0] = rd1[0];
    assign ram_rdata[1] = rd2[1];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_req[k] && ram_gnt && ram_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[k][b]) env_mem[k][ram_addr[k]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
                if (ram_tag_we[k]) env_mem[k][ram_addr[k]][32] <= ram_wdata[k][32];
                rd1[k] <= garbage();
            end else if (ram_req[k] && ram_gnt) begin
                rd1[k] <= env_mem[k][ram_addr[k]];
            end else begin
                rd1[k] <= garbage();
            end
            rd2[k] <= rd1[k];
        end
    end

    // Monitor: every rvalid must match the oldest expectation, at the expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("err_cnt%0d", k), 64'(err_cnt[k]), 64'(cnt_m[k]));
                if (rvalid[k] === 1'b1) begin
                    if (q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rvalid%0d at cycle %0d: got rvalid 1 expected 0", k, cyc);
                    end else begin
                        e = q[k].pop_front();
                        chk($sformatf("rsp_cycle%0d", k), 64'(cyc), 64'(e.cyc));
                        chk($sformatf("rsp_err%0d", k), 64'(data_err[k]), 64'(e.err));
                        chk($sformatf("rsp_rdata%0d", k), 64'(rdata[k]), 64'(e.rdata));
                        if (e.err && cnt_m[k] != 16'hFFFF) cnt_m[k] = cnt_m[k] + 16'd1;
                    end
                end else begin
                    while (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_rvalid%0d at cycle %0d: got rvalid 0 expected 1", k, cyc);
                        void'(q[k].pop_front());
                    end
                end
                if (rst) begin
                    q[k].delete();
                    cnt_m[k] = 0;
                end
            end
        end
    end

    // One core cycle: drive, check the combinational side, record the expected response.
    task automatic step(input bit rq, input bit cp, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [32:0] wd, input bit g, output bit granted);
        longint off;
        bit bd, eg;
        int idx;
        exp_t e;
        logic [32:0] word;
        data_req = rq; data_is_cap = cp; data_we = w; data_be = b;
        data_addr = a; data_wdata = wd; ram_gnt = g;
        @(negedge clk);
        off = longint'(a) - longint'(BASE);
        bd  = !(off >= 0 && off < WIN) || (cp && (b != 4'hF || a % 4 != 0));
        eg  = rq && (bd || g);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt%0d", k), 64'(data_gnt[k]), 64'(eg));
            chk($sformatf("ram_req%0d", k), 64'(ram_req[k]), 64'(rq && !bd));
            if (rq && !bd) begin
                chk($sformatf("ram_addr%0d", k), 64'(ram_addr[k]), 64'(off / 4));
                chk($sformatf("ram_we%0d", k), 64'(ram_we[k]), 64'(w));
                chk($sformatf("ram_be%0d", k), 64'(ram_be[k]), 64'(b));
                chk($sformatf("ram_tag_we%0d", k), 64'(ram_tag_we[k]), 64'(w));
                if (w) chk($sformatf("ram_wdata%0d", k), 64'(ram_wdata[k]), 64'({cp & wd[32], wd[31:0]}));
            end
        end
        if (eg) begin
            e.err = bd;
            e.rdata = '0;
            if (!bd) begin
                idx  = int'(off / 4);
                word = ref_mem.exists(idx) ? ref_mem[idx] : 33'h0;
                if (w) begin
                    for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
                    word[32] = cp ? wd[32] : 1'b0;
                    ref_mem[idx] = word;
                end else begin
                    e.rdata = word;
                end
            end
            for (int k = 0; k < 2; k++) begin
                e.cyc = cyc + LAT[k];
                q[k].push_back(e);
            end
        end
        granted = eg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit gr;
        repeat (n) step(0, 0, 0, 4'h0, 32'h0, 33'h0, 1, gr);
    endtask

    initial begin
        bit gr, c_req, c_cap, c_we;
        logic [3:0] c_be;
        logic [31:0] c_addr;
        logic [32:0] c_wd;
        int sel;
        cyc = 0; checks = 0; errors = 0; armed = 0;
        cnt_m = '{16'h0, 16'h0};
        for (int k = 0; k < 2; k++) for (int i = 0; i < (1 << MAW); i++) env_mem[k][i] = '0;
        data_req = 0; data_is_cap = 0; data_we = 0; data_be = 0;
        data_addr = 0; data_wdata = 0; ram_gnt = 1; rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        armed = 1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rvalid%0d", k), 64'(rvalid[k]), 64'h0);
            chk($sformatf("rst_err%0d", k), 64'(data_err[k]), 64'h0);
            chk($sformatf("rst_rdata%0d", k), 64'(rdata[k]), 64'h0);
            chk($sformatf("rst_cnt%0d", k), 64'(err_cnt[k]), 64'h0);
            chk($sformatf("rst_gnt%0d", k), 64'(data_gnt[k]), 64'h0);
            chk($sformatf("rst_ram_req%0d", k), 64'(ram_req[k]), 64'h0);
        end
        @(posedge clk);
        #1;

        // Capability write then read-back of the same word.
        step(1, 1, 1, 4'hF, BASE + 8, 33'h1_DEADBEEF, 1, gr);
        step(1, 0, 0, 4'hF, BASE + 8, 33'h0, 1, gr);
        idle(3);

        // Tagged word partially overwritten by a plain store loses its tag.
        step(1, 1, 1, 4'hF, BASE + 16, 33'h1_12345678, 1, gr);
        step(1, 0, 1, 4'h1, BASE + 16, 33'h1_000000AB, 1, gr);
        step(1, 1, 0, 4'hF, BASE + 16, 33'h0, 1, gr);
        idle(3);

        // Out-of-window read and a malformed capability access.
        step(1, 0, 0, 4'hF, BASE - 4, 33'h0, 0, gr);
        step(1, 1, 0, 4'h3, BASE + 20, 33'h0, 0, gr);
        step(1, 0, 0, 4'hF, BASE + 32'h0001_0000, 33'h0, 1, gr);
        idle(3);

        // Arbiter stall, then back-to-back reads.
        repeat (3) step(1, 0, 0, 4'hF, BASE + 8, 33'h0, 0, gr);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 4'hF, BASE + 32'(4 * (i + 2)), 33'h0, 1, gr);
        idle(3);

        // Reset while an error and a read are still in flight.
        step(1, 0, 0, 4'hF, BASE - 8, 33'h0, 1, gr);
        step(1, 0, 0, 4'hF, BASE + 8, 33'h0, 1, gr);
        rst = 1;
        idle(1);
        rst = 0;
        idle(4);
        for (int k = 0; k < 2; k++) chk($sformatf("midrst_cnt%0d", k), 64'(err_cnt[k]), 64'h0);

        // Randomized traffic; a stalled request is held until granted.
        gr = 1; c_req = 0; c_cap = 0; c_we = 0; c_be = 0; c_addr = 0; c_wd = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!(c_req && !gr)) begin
                c_req = $urandom_range(0, 9) < 7;
                c_cap = $urandom_range(0, 2) == 0;
                c_we  = 1'($urandom);
                c_be  = (c_cap && $urandom_range(0, 5) != 0) ? 4'hF : 4'($urandom);
                c_wd  = garbage();
                sel   = $urandom_range(0, 9);
                if (sel < 7)
                    c_addr = BASE + 32'($urandom_range(0, 15)) * 4 +
                             (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                else if (sel == 7) c_addr = BASE - 32'($urandom_range(1, 64));
                else if (sel == 8) c_addr = BASE + 32'h0001_0000 + 32'($urandom_range(0, 64));
                else c_addr = $urandom;
            end
            step(c_req, c_cap, c_we, c_be, c_addr, c_wd, $urandom_range(0, 3) != 0, gr);
        end
        idle(4);

        // Counter saturation.
        for (int i = 0; i < 65540; i++) step(1, 0, 0, 4'hF, BASE - 4, 33'h0, 1, gr);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("sat_cnt%0d", k), 64'(err_cnt[k]), 64'hFFFF);
            chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
